// File: rtl/enet_phy_reset_seq.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// enet_phy_reset_seq
//
// Power-up and software reset sequencer for up to four Ethernet PHYs.
//
// Reset sequence per channel:
//   - Hold the PHY in reset for RST_CYCLES clkin_50 edges.
//   - Release it, then wait WAIT_CYCLES edges for it to settle.
//   - Declare it ready for MDIO access.
//
// Each channel has its own FSM and counter, so a software reset request on one
// PHY never disturbs the others.
//
// Optional feature, macro ENET_SPEED_TRACK_EN:
//   - When defined, each channel decodes the MAC speed indication, filters it
//     through two flops, and drives a TX clock select with a one-cycle change
//     pulse.
//   - When undefined, clk_sel is tied to 125 MHz (2'b10), speed_chg is tied
//     low, and eth_mode and ena_10 are ignored.
// -----------------------------------------------------------------------------
module enet_phy_reset_seq #(
    parameter int NUM_PHY     = 1,
    parameter int RST_CYCLES  = 524288,
    parameter int WAIT_CYCLES = 50000,
    parameter int CNT_W       = 21
) (
    input  logic                 clkin_50,
    input  logic                 cpu_reset,
    input  logic [NUM_PHY-1:0]   sw_rst_req,
    input  logic [NUM_PHY-1:0]   eth_mode,
    input  logic [NUM_PHY-1:0]   ena_10,
    output logic [NUM_PHY-1:0]   enet_resetn,
    output logic [NUM_PHY-1:0]   phy_ready,
    output logic [2*NUM_PHY-1:0] clk_sel,
    output logic [NUM_PHY-1:0]   speed_chg,
    output logic                 busy
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    localparam int MAX_CYCLES = (RST_CYCLES > WAIT_CYCLES) ? RST_CYCLES : WAIT_CYCLES;

    if (NUM_PHY < 1 || NUM_PHY > 4) begin : g_bad_num_phy
        $error("enet_phy_reset_seq: NUM_PHY must be in 1..4");
    end
    if (RST_CYCLES < 2) begin : g_bad_rst_cycles
        $error("enet_phy_reset_seq: RST_CYCLES must be at least 2");
    end
    if (WAIT_CYCLES < 2) begin : g_bad_wait_cycles
        $error("enet_phy_reset_seq: WAIT_CYCLES must be at least 2");
    end
    if (CNT_W < 1 || CNT_W > 31 ||
        (longint'(MAX_CYCLES) - 1) >= (longint'(1) << CNT_W)) begin : g_bad_cnt_w
        $error("enet_phy_reset_seq: CNT_W too narrow for max(RST_CYCLES, WAIT_CYCLES)-1");
    end

    // Terminal counts.
    // The compares are exact and the counter clears on every transition,
    // so the counter can never wrap.
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        RST_ASSERT = 2'd0,
        RST_WAIT   = 2'd1,
        READY      = 2'd2
    } phy_state_e;

    phy_state_e       state_q [NUM_PHY];
    phy_state_e       state_d [NUM_PHY];
    logic [CNT_W-1:0] cnt_q   [NUM_PHY];
    logic [CNT_W-1:0] cnt_d   [NUM_PHY];

    logic [NUM_PHY-1:0] resetn_d;
    logic [NUM_PHY-1:0] ready_d;
    logic               busy_d;

    // -------------------------------------------------------------------------
    // Reset sequencer FSM
    // -------------------------------------------------------------------------

    // State register: per-channel FSM state and counter; cpu_reset parks every channel.
    always_ff @(posedge clkin_50) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (cpu_reset) begin
            for (int i = 0; i < NUM_PHY; i++) begin
                state_q[i] <= RST_ASSERT;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PHY; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Next-state logic: a software request overrides every state and restarts the count.
    always_comb begin
        for (int i = 0; i < NUM_PHY; i++) begin
            // NOTE: defaults first so every path assigns every output; a path
            // left unassigned in always_comb would infer a latch.
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];

            if (sw_rst_req[i]) begin
                state_d[i] = RST_ASSERT;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    RST_ASSERT: begin
                        if (cnt_q[i] == RST_LAST) begin
                            state_d[i] = RST_WAIT;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    RST_WAIT: begin
                        if (cnt_q[i] == WAIT_LAST) begin
                            state_d[i] = READY;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    READY: begin
                        cnt_d[i] = '0;
                    end
                    default: begin
                        state_d[i] = RST_ASSERT;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    // Output decode from the next state, so the registered outputs change on the transition edge.
    always_comb begin
        resetn_d = '0;
        ready_d  = '0;
        for (int i = 0; i < NUM_PHY; i++) begin
            resetn_d[i] = (state_d[i] != RST_ASSERT);
            ready_d[i]  = (state_d[i] == READY);
        end
        busy_d = ~&ready_d;
    end

    // Output register: reset values take priority over any pending transition.
    always_ff @(posedge clkin_50) begin
        if (cpu_reset) begin
            enet_resetn <= '0;
            phy_ready   <= '0;
            busy        <= 1'b1;
        end else begin
            enet_resetn <= resetn_d;
            phy_ready   <= ready_d;
            busy        <= busy_d;
        end
    end

    // -------------------------------------------------------------------------
    // TX clock select tracking
    // -------------------------------------------------------------------------
`ifdef ENET_SPEED_TRACK_EN

    logic [NUM_PHY-1:0][1:0] spd_dec;
    logic [NUM_PHY-1:0][1:0] spd_s1;
    logic [NUM_PHY-1:0][1:0] spd_s2;

    // Speed decode: GbE wins over 10 Mb, otherwise 100 Mb (25 MHz).
    always_comb begin
        spd_dec = '0;
        for (int i = 0; i < NUM_PHY; i++) begin
            if (eth_mode[i]) begin
                spd_dec[i] = 2'b10;
            end else if (ena_10[i]) begin
                spd_dec[i] = 2'b01;
            end else begin
                spd_dec[i] = 2'b00;
            end
        end
    end

    // Two-flop filter; clk_sel moves only on a decode stable for two samples, pulsing speed_chg.
    always_ff @(posedge clkin_50) begin
        if (cpu_reset) begin
            spd_s1    <= '0;
            spd_s2    <= '0;
            clk_sel   <= '0;
            speed_chg <= '0;
        end else begin
            spd_s1 <= spd_dec;
            spd_s2 <= spd_s1;
            for (int i = 0; i < NUM_PHY; i++) begin
                if (spd_s1[i] == spd_s2[i] && spd_s2[i] != clk_sel[2*i +: 2]) begin
                    clk_sel[2*i +: 2] <= spd_s2[i];
                    speed_chg[i]      <= 1'b1;
                end else begin
                    speed_chg[i]      <= 1'b0;
                end
            end
        end
    end

`else

    // Speed tracking not built: fixed 125 MHz select, no change pulses.
    assign clk_sel   = {NUM_PHY{2'b10}};
    assign speed_chg = '0;

    // MAC speed indications are intentionally unused in this build.
    logic unused_speed_inputs;
    assign unused_speed_inputs = ^{eth_mode, ena_10};

`endif

endmodule

// File: tb/tb_enet_phy_reset_seq.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_enet_phy_reset_seq
//
// Scoreboard bench for enet_phy_reset_seq.
//   - Configuration: NUM_PHY=2, RST_CYCLES=8, WAIT_CYCLES=4.
//   - Each step drives the inputs for the next clkin_50 edge.
//   - The reference model then pushes the outputs expected after that edge
//     onto a queue.
//   - Each test task pops the entry at the following negedge and compares it
//     with the DUT outputs.
//
// The bench follows the ENET_SPEED_TRACK_EN setting used for the RTL build.
// -----------------------------------------------------------------------------
module tb_enet_phy_reset_seq;

    localparam int NUM_PHY     = 2;
    localparam int RST_CYCLES  = 8;
    localparam int WAIT_CYCLES = 4;
    localparam int CNT_W       = 4;

    typedef struct packed {
        logic [1:0] resetn;
        logic [1:0] ready;
        logic       busy;
        logic [3:0] sel;
        logic [1:0] chg;
    } obs_t;

    logic                 clkin_50 = 1'b0;
    logic                 cpu_reset;
    logic [NUM_PHY-1:0]   sw_rst_req;
    logic [NUM_PHY-1:0]   eth_mode;
    logic [NUM_PHY-1:0]   ena_10;
    logic [NUM_PHY-1:0]   enet_resetn;
    logic [NUM_PHY-1:0]   phy_ready;
    logic [2*NUM_PHY-1:0] clk_sel;
    logic [NUM_PHY-1:0]   speed_chg;
    logic                 busy;

    int   pass_cnt = 0;
    int   chk_cnt  = 0;
    int   edge_no  = 0;
    obs_t exp_q[$];

    // Reference model state.
    // rel[i] counts edges since channel i was last held in reset;
    // hist1/hist2 are the speed decodes seen on the last two edges.
    int         rel   [NUM_PHY];
    logic [1:0] hist1 [NUM_PHY];
    logic [1:0] hist2 [NUM_PHY];
    logic [1:0] sel_m [NUM_PHY];
    logic       chg_m [NUM_PHY];

    always #5 clkin_50 = ~clkin_50;

    enet_phy_reset_seq #(
        .NUM_PHY     (NUM_PHY),
        .RST_CYCLES  (RST_CYCLES),
        .WAIT_CYCLES (WAIT_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clkin_50    (clkin_50),
        .cpu_reset   (cpu_reset),
        .sw_rst_req  (sw_rst_req),
        .eth_mode    (eth_mode),
        .ena_10      (ena_10),
        .enet_resetn (enet_resetn),
        .phy_ready   (phy_ready),
        .clk_sel     (clk_sel),
        .speed_chg   (speed_chg),
        .busy        (busy)
    );

    function automatic obs_t observe();
        obs_t o;
        o.resetn = enet_resetn;
        o.ready  = phy_ready;
        o.busy   = busy;
        o.sel    = clk_sel;
        o.chg    = speed_chg;
        return o;
    endfunction

    function automatic logic [1:0] decode(input logic eth, input logic e10);
        if (eth) return 2'b10;
        if (e10) return 2'b01;
        return 2'b00;
    endfunction

    // Drive one edge's inputs, push the model's expected outputs, wait to the negedge.
    task automatic step(input logic rst, input logic [1:0] sw,
                        input logic [1:0] eth, input logic [1:0] e10);
        obs_t e;
        cpu_reset  = rst;
        sw_rst_req = sw;
        eth_mode   = eth;
        ena_10     = e10;

        e = '0;
        for (int i = 0; i < NUM_PHY; i++) begin
            if (rst || sw[i]) begin
                rel[i] = 0;
            end else if (rel[i] < 1000) begin
                rel[i] = rel[i] + 1;
            end
            e.resetn[i] = (rel[i] >= RST_CYCLES);
            e.ready[i]  = (rel[i] >= RST_CYCLES + WAIT_CYCLES);

`ifdef ENET_SPEED_TRACK_EN
            if (rst) begin
                hist1[i] = 2'b00;
                hist2[i] = 2'b00;
                sel_m[i] = 2'b00;
                chg_m[i] = 1'b0;
            end else begin
                chg_m[i] = 1'b0;
                if (hist1[i] == hist2[i] && hist1[i] != sel_m[i]) begin
                    sel_m[i] = hist1[i];
                    chg_m[i] = 1'b1;
                end
                hist2[i] = hist1[i];
                hist1[i] = decode(eth[i], e10[i]);
            end
`else
            sel_m[i] = 2'b10;
            chg_m[i] = 1'b0;
`endif
            e.sel[2*i +: 2] = sel_m[i];
            e.chg[i]        = chg_m[i];
        end
        e.busy = ~&e.ready;

        exp_q.push_back(e);
        @(negedge clkin_50);
        edge_no++;
    endtask

    task automatic test_reset();
        obs_t e;
        obs_t g;
        for (int n = 0; n < 3; n++) begin
            step(1'b1, 2'(n), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            e = exp_q.pop_front();
            g = observe();
            chk_cnt++;
            if (g !== e)
                $display("FAIL reset edge %0d: got resetn=%b ready=%b busy=%b clk_sel=%b chg=%b, required resetn=%b ready=%b busy=%b clk_sel=%b chg=%b",
                         edge_no, g.resetn, g.ready, g.busy, g.sel, g.chg, e.resetn, e.ready, e.busy, e.sel, e.chg);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_power_up();
        obs_t e;
        obs_t g;
        for (int n = 0; n < 16; n++) begin
            step(1'b0, 2'b00, 2'b00, 2'b00);
            e = exp_q.pop_front();
            g = observe();
            chk_cnt++;
            if (g !== e)
                $display("FAIL power_up edge %0d: got resetn=%b ready=%b busy=%b clk_sel=%b chg=%b, required resetn=%b ready=%b busy=%b clk_sel=%b chg=%b",
                         edge_no, g.resetn, g.ready, g.busy, g.sel, g.chg, e.resetn, e.ready, e.busy, e.sel, e.chg);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_sw_reset();
        obs_t e;
        obs_t g;
        // One-cycle request on channel 0, then a 3-cycle held request on channel 1.
        for (int n = 0; n < 34; n++) begin
            logic [1:0] sw;
            sw = 2'b00;
            if (n == 0) sw = 2'b01;
            if (n >= 16 && n < 19) sw = 2'b10;
            step(1'b0, sw, 2'b00, 2'b00);
            e = exp_q.pop_front();
            g = observe();
            chk_cnt++;
            if (g !== e)
                $display("FAIL sw_reset edge %0d: got resetn=%b ready=%b busy=%b clk_sel=%b chg=%b, required resetn=%b ready=%b busy=%b clk_sel=%b chg=%b",
                         edge_no, g.resetn, g.ready, g.busy, g.sel, g.chg, e.resetn, e.ready, e.busy, e.sel, e.chg);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_sequence();
        obs_t e;
        obs_t g;
        // Reset, release for 5 edges, reset again (with sw requests), release for 15 edges.
        for (int n = 0; n < 22; n++) begin
            logic       rst;
            logic [1:0] sw;
            rst = (n == 0) || (n == 6);
            sw  = (n == 6) ? 2'b11 : 2'b00;
            step(rst, sw, 2'b00, 2'b00);
            e = exp_q.pop_front();
            g = observe();
            chk_cnt++;
            if (g !== e)
                $display("FAIL reset_mid_sequence edge %0d: got resetn=%b ready=%b busy=%b clk_sel=%b chg=%b, required resetn=%b ready=%b busy=%b clk_sel=%b chg=%b",
                         edge_no, g.resetn, g.ready, g.busy, g.sel, g.chg, e.resetn, e.ready, e.busy, e.sel, e.chg);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_speed_track();
        obs_t       e;
        obs_t       g;
        logic [1:0] eth_seq [36];
        logic [1:0] e10_seq [36];
        for (int n = 0; n < 36; n++) begin
            eth_seq[n] = 2'b00;
            e10_seq[n] = 2'b00;
        end
        for (int n = 3;  n < 8;  n++) eth_seq[n] = 2'b10;  // ch1 to GbE
        e10_seq[12] = 2'b10;                                // 1-cycle glitch on ch1
        for (int n = 17; n < 22; n++) begin                 // ch0: both set -> GbE
            eth_seq[n] = 2'b01;
            e10_seq[n] = 2'b01;
        end
        for (int n = 22; n < 36; n++) e10_seq[n] = 2'b01;   // ch0 to 10 Mb
        eth_seq[28] = 2'b01;                                // 1-cycle GbE glitch on ch0
        for (int n = 0; n < 36; n++) begin
            step(1'b0, 2'b00, eth_seq[n], e10_seq[n]);
            e = exp_q.pop_front();
            g = observe();
            chk_cnt++;
            if (g !== e)
                $display("FAIL speed_track edge %0d: got resetn=%b ready=%b busy=%b clk_sel=%b chg=%b, required resetn=%b ready=%b busy=%b clk_sel=%b chg=%b",
                         edge_no, g.resetn, g.ready, g.busy, g.sel, g.chg, e.resetn, e.ready, e.busy, e.sel, e.chg);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        obs_t e;
        obs_t g;
        // Requests on consecutive edges to different channels.
        for (int n = 0; n < 16; n++) begin
            logic [1:0] sw;
            sw = (n == 0) ? 2'b01 : (n == 1) ? 2'b10 : 2'b00;
            step(1'b0, sw, 2'b00, 2'b01);
            e = exp_q.pop_front();
            g = observe();
            chk_cnt++;
            if (g !== e)
                $display("FAIL back_to_back edge %0d: got resetn=%b ready=%b busy=%b clk_sel=%b chg=%b, required resetn=%b ready=%b busy=%b clk_sel=%b chg=%b",
                         edge_no, g.resetn, g.ready, g.busy, g.sel, g.chg, e.resetn, e.ready, e.busy, e.sel, e.chg);
            else
                pass_cnt++;
        end
    endtask

    initial begin
        cpu_reset  = 1'b1;
        sw_rst_req = '0;
        eth_mode   = '0;
        ena_10     = '0;
        for (int i = 0; i < NUM_PHY; i++) begin
            rel[i]   = 0;
            hist1[i] = 2'b00;
            hist2[i] = 2'b00;
            sel_m[i] = 2'b00;
            chg_m[i] = 1'b0;
        end

        test_reset();
        test_power_up();
        test_sw_reset();
        test_reset_mid_sequence();
        test_speed_track();
        test_back_to_back();

        chk_cnt++;
        if (exp_q.size() != 0)
            $display("FAIL scoreboard_drain: got %0d entries left, required 0", exp_q.size());
        else
            pass_cnt++;

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/enet_phy_reset_seq.md
ENET_PHY_RESET_SEQ -- requirements
Module: enet_phy_reset_seq

Interface
REQ-001 Parameter NUM_PHY, default 1, meaning: number of independent PHY channels, legal range 1..4.
REQ-002 Parameter RST_CYCLES, default 524288, meaning: PHY reset assertion length in clkin_50 cycles (about 10.5 ms at 50 MHz), legal minimum 2.
REQ-003 Parameter WAIT_CYCLES, default 50000, meaning: post-reset settle time before the PHY is declared ready (about 1 ms), legal minimum 2.
REQ-004 Parameter CNT_W, default 21, meaning: per-channel counter width; it SHALL hold max(RST_CYCLES, WAIT_CYCLES)-1, checked at elaboration.
REQ-005 Clocking and reset (decided): one clock, clkin_50; reset is synchronous and active-high, named cpu_reset.
REQ-006 clkin_50  in  1  sole clock; all state changes on its rising edge.
REQ-007 cpu_reset  in  1  synchronous active-high reset.
REQ-008 sw_rst_req  in  NUM_PHY  per-channel software reset request, one bit per PHY, level-sampled each edge.
REQ-009 eth_mode  in  NUM_PHY  per-channel MAC GbE indication.
REQ-010 ena_10  in  NUM_PHY  per-channel MAC 10 Mb indication.
REQ-011 enet_resetn  out  NUM_PHY  per-channel active-low PHY reset, registered.
REQ-012 phy_ready  out  NUM_PHY  per-channel flag: PHY released and settled, MDIO access permitted, registered.
REQ-013 clk_sel  out  2*NUM_PHY  per-channel TX clock select, bits [2i+1:2i] for channel i: 00 = 25 MHz, 01 = 2.5 MHz, 10 = 125 MHz; 11 is never driven.
REQ-014 speed_chg  out  NUM_PHY  per-channel one-cycle pulse on every clk_sel update.
REQ-015 busy  out  1  OR of all channels not in READY, registered.

Function
REQ-016 Each channel SHALL run its own FSM with states RST_ASSERT, RST_WAIT and READY, plus its own CNT_W-bit counter.
REQ-017 RST_ASSERT: enet_resetn=0 and phy_ready=0; the counter increments each edge; on the edge where count = RST_CYCLES-1, the FSM goes to RST_WAIT and the counter clears.
REQ-018 RST_WAIT: enet_resetn=1 and phy_ready=0; on the edge where count = WAIT_CYCLES-1, the FSM goes to READY and the counter clears.
REQ-019 READY: enet_resetn=1 and phy_ready=1; the counter holds at 0.
REQ-020 sw_rst_req[i]=1 in any state SHALL force channel i to RST_ASSERT with count 0 on that edge; a held request keeps the channel in reset, and RST_CYCLES counts from the first edge with the request low.
REQ-021 A request on one channel SHALL NOT disturb any other channel.
REQ-022 Timing: enet_resetn[i] rises on the RST_CYCLES-th edge after reset or request removal; phy_ready[i] rises WAIT_CYCLES edges after that.
REQ-023 Speed decode priority: eth_mode gives 10, else ena_10 gives 01, else 00.
REQ-024 The decoded speed SHALL pass through a 2-flop register; clk_sel[i] updates only when both flops agree and differ from the current clk_sel[i].
REQ-025 speed_chg[i] SHALL pulse on the same edge as each clk_sel[i] update; a decode that toggles for a single cycle SHALL NOT cause an update.
REQ-026 Counters SHALL never wrap: terminal compares are exact and each counter clears on every state transition.

Reset
REQ-027 While cpu_reset=1, all channels SHALL be in RST_ASSERT with count 0.
REQ-028 Reset values: enet_resetn all 0, phy_ready all 0, busy=1, speed_chg all 0, clk_sel all 00, speed-filter flops 00.
REQ-029 cpu_reset asserted mid-sequence, or together with sw_rst_req, SHALL give the reset values on the next edge; reset takes priority.

Configuration
REQ-030 Macro ENET_SPEED_TRACK_EN defined: speed decode, filter, clk_sel and speed_chg behave as in REQ-023 to REQ-025.
REQ-031 Macro ENET_SPEED_TRACK_EN undefined: no filter logic is built; clk_sel is tied to 10 for every channel; speed_chg is tied to 0; eth_mode and ena_10 are ignored.

Verification (bench parameters: RST_CYCLES=8, WAIT_CYCLES=4, NUM_PHY=2)
REQ-032 Release cpu_reset at edge 0 -> enet_resetn=11 from edge 8; phy_ready=11 and busy=0 from edge 12.
REQ-033 sw_rst_req=01 for one cycle in READY -> enet_resetn[0]=0 for 8 edges and phy_ready[0] returns 4 edges later; channel 1 stays ready throughout.
REQ-034 cpu_reset pulsed at edge 6 of the first sequence -> all outputs return to reset values; resetn rises 8 edges after the new release.
REQ-035 eth_mode[1] goes 0->1 and holds -> clk_sel[3:2]=10 with a one-cycle speed_chg[1] pulse, 2-3 edges later; a 1-cycle glitch on ena_10[1] -> no change.
REQ-036 eth_mode=1 and ena_10=1 on the same channel -> clk_sel=10; with ENET_SPEED_TRACK_EN undefined, any inputs -> clk_sel=1010 and speed_chg=00.
